// File: rtl/gry_conv_arbiter.sv
// gry_conv_arbiter: round-robin arbiter that shares one binary-to-Gray
// conversion stage among NREQ valid/ready requesters. The registered output is
// tagged with the winning requester index.
// Optional build macro GRY_SELFCHK_EN adds a Gray->binary back-conversion
// checker that raises a sticky chk_err on mismatch. Without it, chk_err is 0.
`timescale 1ns/1ps
module gry_conv_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_gray,
    output logic [IDW-1:0]      out_id,
    output logic [CNTW-1:0]     conv_cnt,
    output logic                chk_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic            slot_free;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    int unsigned     scan_idx;
    logic [N-1:0]    sel_bin;
    logic [N-1:0]    gray_next;

    assign slot_free = (state == EMPTY) | (out_valid & out_ready);

    // Round-robin scan starting at rr_ptr; first valid requester wins while the stage can accept.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (rr_ptr + k) % NREQ;
            if (!grant_any && slot_free && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_id        = IDW'(scan_idx);
                grant_any       = 1'b1;
            end
        end
    end

    assign req_ready = rst ? '0 : grant;

    // Select the winner's word and convert it to Gray code.
    always_comb begin
        sel_bin   = req_data[grant_id*N +: N];
        gray_next = {sel_bin[N-1], sel_bin[N-1:1] ^ sel_bin[N-2:0]};
    end

    // Output stage FSM, round-robin pointer and conversion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_id    <= '0;
            conv_cnt  <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (grant_any) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_gray  <= gray_next;
                        out_id    <= grant_id;
                    end
                end
                FULL: begin
                    if (grant_any) begin
                        // drain and reload in the same cycle
                        out_gray  <= gray_next;
                        out_id    <= grant_id;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
            if (grant_any) begin
                rr_ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                conv_cnt <= conv_cnt + 1'b1;
            end
        end
    end

`ifdef GRY_SELFCHK_EN
    logic [N-1:0] bin_q;
    logic [N-1:0] back_bin;
    logic         back_acc;

    // Keep the binary word that produced the current Gray output.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
        end else if (grant_any) begin
            bin_q <= sel_bin;
        end
    end

    // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        back_bin = '0;
        back_acc = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            back_acc             = back_acc ^ out_gray[N-1-k];
            back_bin[N-1-k]      = back_acc;
        end
    end

    // Sticky error whenever a held word fails the round trip.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (out_valid && (back_bin != bin_q)) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gry_conv_arbiter.sv
// Testbench for gry_conv_arbiter: directed vectors, scoreboard queue filled at
// grant time and drained by an independent output monitor.
`timescale 1ns/1ps
module tb_gry_conv_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_gray;
    logic [IDW-1:0]      out_id;
    logic [CNTW-1:0]     conv_cnt;
    logic                chk_err;

    gry_conv_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_id    (out_id),
        .conv_cnt  (conv_cnt),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]   gray;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    logic            m_full = 1'b0;
    logic [IDW-1:0]  m_rr   = '0;
    logic [CNTW-1:0] m_cnt  = '0;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        logic [N-1:0] g;
        g[N-1] = b[N-1];
        for (int i = 0; i < N-1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; predicts the grant and queues the expected output.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] d, input logic ordy);
        logic [NREQ-1:0] exp_g;
        int              gid;
        int              idx;
        bit              found;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        #1;
        exp_g = '0;
        gid   = 0;
        found = 0;
        if (!m_full || ordy) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(m_rr) + k) % NREQ;
                if (!found && v[idx]) begin
                    found      = 1;
                    gid        = idx;
                    exp_g[idx] = 1'b1;
                end
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_g));
        if (found) begin
            sbq.push_back({to_gray(d[gid*N +: N]), IDW'(gid)});
            m_rr   = IDW'((gid + 1) % NREQ);
            m_cnt  = m_cnt + 1'b1;
            m_full = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic apply_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            rst       = 1'b1;
            req_valid = 4'hF;
            out_ready = 1'b1;
            #1;
            check("rst_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_conv_cnt", 32'(conv_cnt), 32'h0);
        check("rst_chk_err", 32'(chk_err), 32'h0);
        rst       = 1'b0;
        req_valid = '0;
        sbq.delete();
        m_full = 1'b0;
        m_rr   = '0;
        m_cnt  = '0;
    endtask

    // Output monitor: every accepted output must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got gray=%0h id=%0d expected none", out_gray, out_id);
                end else begin
                    e = sbq.pop_front();
                    check("out_gray", 32'(out_gray), 32'(e.gray));
                    check("out_id", 32'(out_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rr_tbl [8];
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // 1: reset
        apply_reset(2);

        // 2: single request from requester 2
        step(4'b0100, 32'h002D_0000, 1'b1);
        check("t2_grant", 32'(req_ready), 32'h4);
        step(4'b0000, 32'h0, 1'b1);
        check("t2_gray", 32'(out_gray), 32'h3B);
        check("t2_id", 32'(out_id), 32'h2);
        check("t2_cnt", 32'(conv_cnt), 32'h1);

        // 3: round-robin with all requesters valid
        apply_reset(2);
        rr_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 32'h4433_2211 + 32'(i), 1'b1);
            check("t3_rr_order", 32'(req_ready), 32'(rr_tbl[i]));
        end
        step(4'b0000, 32'h0, 1'b1);
        check("t3_cnt", 32'(conv_cnt), 32'h8);

        // 4: backpressure holds the stage
        step(4'b0001, 32'h0000_00FF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 32'h5566_7788, 1'b0);
            check("t4_hold_gray", 32'(out_gray), 32'h80);
            check("t4_hold_id", 32'(out_id), 32'h0);
            check("t4_hold_ready", 32'(req_ready), 32'h0);
        end
        step(4'hF, 32'h1122_3344, 1'b1);
        check("t4_regrant", 32'(req_ready), 32'h2);

        // 5: requester 1 conversions, corner words then full sweep
        step(4'b0010, 32'h0000_7F00, 1'b1);
        step(4'b0010, 32'h0000_8000, 1'b1);
        check("t5_gray_7F", 32'(out_gray), 32'h40);
        step(4'b0000, 32'h0, 1'b1);
        check("t5_gray_80", 32'(out_gray), 32'hC0);
        for (int i = 0; i < 256; i++) begin
            step(4'b0010, 32'(i) << 8, 1'b1);
        end
        step(4'b0000, 32'h0, 1'b1);
        check("t5_chk_err", 32'(chk_err), 32'h0);

        // 6: counter wrap, then reset while a word is held
        while (m_cnt != 16'hFFFF) begin
            step(4'hF, 32'hA5C3_0F96, 1'b1);
        end
        step(4'b0000, 32'h0, 1'b1);
        check("t6_cnt_max", 32'(conv_cnt), 32'hFFFF);
        step(4'b0100, 32'h00AA_0000, 1'b1);
        step(4'b0000, 32'h0, 1'b0);
        check("t6_cnt_wrap", 32'(conv_cnt), 32'h0);
        check("t6_held_valid", 32'(out_valid), 32'h1);
        apply_reset(1);
        step(4'hF, 32'h0102_0304, 1'b1);
        check("t6_post_rst_grant", 32'(req_ready), 32'h1);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b1);
        check("t6_post_rst_valid", 32'(out_valid), 32'h0);
        check("sb_drained", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
